op_solve: RTL and testbench
===========================

Name: op_solve

Overview:
- Inverse of the parameterised operand-combining unit (z = f(a,b) selected by OPERATION_TYPE).
- Given a 64-bit result z and the known operand b, it recovers operand a and flags results that no 32-bit a could have produced.
- Arithmetic is digit-serial, DIGIT_W bits per cycle, to save area on the checker/solver path.
- Valid/ready handshake on both the input and output sides.

Parameters:
- OPERATION_TYPE, 0: forward function being inverted. 0: z={a[0]&b[0],63'b0}; 1: z=a-b; 2: z=(a<<1)+b; 3 (or any other value): z=b-a. All forward arithmetic is 64-bit with a and b zero-extended.
- DIGIT_W, 8: bits processed per CALC cycle. Legal values are 1, 2, 4, 8, 16, 32, 64. NUM_DIGITS = 64/DIGIT_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- z_in  in  64  forward result.
- b_in  in  32  known operand b.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- a_out  out  32  recovered operand a.
- err_out  out  1  z is unreachable for any 32-bit a, given b.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async assert, sync release) values: state=IDLE, in_ready=1, out_valid=0, a_out=0, err_out=0, busy=0, digit counter=0, carry/borrow=0.
- FSM states: IDLE, CALC, FIN, DONE.
  - IDLE: in_ready=1. On in_valid, capture z_in and b_in (b zero-extended to 64 bits), clear carry, counter=0, go to CALC.
  - CALC: one DIGIT_W slice per cycle, LSB first, with a registered carry/borrow between slices. After NUM_DIGITS cycles, go to FIN.
  - FIN: apply the final shift and error checks, load a_out and err_out, go to DONE.
  - DONE: out_valid=1. a_out and err_out hold stable until out_ready=1, then go to IDLE.
- in_ready is high only in IDLE. There is no same-cycle re-accept in DONE, so there is one idle cycle between jobs.
- Latency: input accepted at edge 0; out_valid rises NUM_DIGITS+1 edges later (9 for DIGIT_W=8). Fixed for every OPERATION_TYPE, including type 0.
- Per-type serial operation r (64-bit, mod 2^64) and result:
  - Type 0: no arithmetic; the CALC cycles accumulate an OR of z[62:0]. a_out={31'b0,z[63]}. err = (z[62:0]!=0) or (z[63] & ~b[0]).
  - Type 1: r=z+b. a_out=r[31:0]. err = (r[63:32]!=0).
  - Type 2: r=z-b with the final borrow kept. a_out=r[32:1]. err = borrow or r[0] or (r[63:33]!=0).
  - Type 3: r=b-z. a_out=r[31:0]. err = (r[63:32]!=0).
- a_out is always loaded (truncated value) even when err_out=1.
- The carry/borrow out of the top digit is discarded except for the type 2 borrow.
- in_valid is ignored outside IDLE. z_in and b_in need only be stable in the accept cycle.
- out_ready is ignored outside DONE.
- rst_n asserted mid-CALC/FIN/DONE: immediate return to reset values. The in-flight job is lost and no out_valid pulse is produced.

Test Plan:
1. OPERATION_TYPE=1, DIGIT_W=8: z=64'h5, b=3 -> a_out=8, err_out=0. out_valid exactly 9 cycles after accept; in_ready=0 throughout.
2. OPERATION_TYPE=1: z=64'hFFFF_FFFF_FFFF_FFFF, b=1 -> a_out=0, err_out=0 (wrap). Then z=64'h1_0000_0000, b=0 -> err_out=1, a_out=0.
3. OPERATION_TYPE=2: z=43, b=3 -> a_out=20, err=0. z=44, b=3 -> a_out=20, err=1 (odd). z=2, b=3 -> err=1 (borrow).
4. OPERATION_TYPE=3: z=64'hFFFF_FFFF_FFFF_FFFE, b=5 -> a_out=7, err=0. OPERATION_TYPE=0: z=64'h8000_0000_0000_0000 with b=1 -> a=1, err=0; with b=0 -> err=1; z=64'h1 -> err=1.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, a_out and err_out are stable and in_ready=0. Release -> IDLE next cycle; a back-to-back second job completes correctly.
6. Assert rst_n low during CALC digit 3 -> all outputs at reset values asynchronously. After release, a new job (type 1, z=10, b=10 -> a=20) is correct. Repeat cases 1 and 3 with DIGIT_W=1 (latency 65) and DIGIT_W=64 (latency 2).

Source files
------------

// File: rtl/op_solve.sv
// Digit-serial inverse of the operand-combining unit: recovers a from z = f(a,b) and flags
// results that no 32-bit a could have produced.
//
// state | meaning
// IDLE  | in_ready high, waiting for a request
// CALC  | one DIGIT_W slice per cycle, LSB first, carry/borrow registered between slices
// FIN   | final shift and range checks, load a_out/err_out
// DONE  | out_valid high, result held until out_ready
module op_solve #(
  parameter int OPERATION_TYPE = 0,
  parameter int DIGIT_W        = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] z_in,
  input  logic [31:0] b_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] a_out,
  output logic        err_out,
  output logic        busy
);

  localparam int NUM_DIGITS = 64 / DIGIT_W;
  localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;

  state_t             state, state_nxt;
  logic               accept, load_result, last_digit;
  logic [CNT_W-1:0]   cnt;
  logic [63:0]        z_sr, b_sr, r_sr;
  logic               carry, or_acc;

  logic [DIGIT_W-1:0] z_dig, b_dig, keep_mask;
  logic [DIGIT_W:0]   dig_sum;
  logic [63:0]        sum_ext, r_nxt, z_rot, b_rot;
  logic [31:0]        a_nxt;
  logic               err_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    accept      = 1'b0;
    load_result = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: if (last_digit) state_nxt = FIN;
      FIN: begin
        load_result = 1'b1;
        state_nxt   = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign last_digit = (cnt == LAST_DIGIT);

  // z and b rotate rather than shift so their original values are back in place at FIN.
  always_comb begin
    z_dig     = z_sr[DIGIT_W-1:0];
    b_dig     = b_sr[DIGIT_W-1:0];
    keep_mask = '1;
    if (last_digit) keep_mask[DIGIT_W-1] = 1'b0;
    case (OPERATION_TYPE)
      0:       dig_sum = '0;
      1:       dig_sum = {1'b0, z_dig} + {1'b0, b_dig} + {{DIGIT_W{1'b0}}, carry};
      2:       dig_sum = {1'b0, z_dig} - {1'b0, b_dig} - {{DIGIT_W{1'b0}}, carry};
      default: dig_sum = {1'b0, b_dig} - {1'b0, z_dig} - {{DIGIT_W{1'b0}}, carry};
    endcase
    sum_ext                = '0;
    sum_ext[DIGIT_W-1:0]   = dig_sum[DIGIT_W-1:0];
    r_nxt = (r_sr >> DIGIT_W) | (sum_ext << (64 - DIGIT_W));
    z_rot = (z_sr >> DIGIT_W) | (z_sr << (64 - DIGIT_W));
    b_rot = (b_sr >> DIGIT_W) | (b_sr << (64 - DIGIT_W));
  end

  always_comb begin
    case (OPERATION_TYPE)
      0: begin
        a_nxt   = {31'b0, z_sr[63]};
        err_nxt = or_acc | (z_sr[63] & ~b_sr[0]);
      end
      2: begin
        a_nxt   = r_sr[32:1];
        err_nxt = carry | r_sr[0] | (|r_sr[63:33]);
      end
      default: begin
        a_nxt   = r_sr[31:0];
        err_nxt = |r_sr[63:32];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_sr    <= '0;
      b_sr    <= '0;
      r_sr    <= '0;
      carry   <= 1'b0;
      or_acc  <= 1'b0;
      cnt     <= '0;
      a_out   <= '0;
      err_out <= 1'b0;
    end else begin
      if (accept) begin
        z_sr   <= z_in;
        b_sr   <= {32'b0, b_in};
        r_sr   <= '0;
        carry  <= 1'b0;
        or_acc <= 1'b0;
        cnt    <= '0;
      end else if (state == CALC) begin
        z_sr   <= z_rot;
        b_sr   <= b_rot;
        r_sr   <= r_nxt;
        carry  <= dig_sum[DIGIT_W];
        or_acc <= or_acc | (|(z_dig & keep_mask));
        cnt    <= cnt + 1'b1;
      end
      if (load_result) begin
        a_out   <= a_nxt;
        err_out <= err_nxt;
      end
    end
  end

endmodule

// File: tb/tb_op_solve.sv
// Drives every job into ten op_solve instances (mixed operation type and digit width) and
// checks each one cycle by cycle against a plain-arithmetic reference.
`timescale 1ns/1ps
module tb_op_solve;
  localparam int NI = 10;
  localparam int TYP [NI] = '{1, 2, 3, 0, 1, 2, 1, 2, 0, 3};
  localparam int WID [NI] = '{8, 8, 8, 8, 1, 1, 64, 64, 1, 64};

  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [63:0] z_in = '0;
  logic [31:0] b_in = '0;
  logic [NI-1:0] in_ready_v, out_valid_v, err_v, busy_v;
  logic [31:0] a_v [NI];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    op_solve #(.OPERATION_TYPE(TYP[g]), .DIGIT_W(WID[g])) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[g]),
      .z_in(z_in), .b_in(b_in), .out_valid(out_valid_v[g]), .out_ready(out_ready),
      .a_out(a_v[g]), .err_out(err_v[g]), .busy(busy_v[g]));
  end

  task automatic chk(string name, int inst, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d actual=%0h required=%0h", name, inst, act, exp);
    end
  endtask

  // Reference: which 32-bit a (if any) maps to z under each forward function.
  function automatic void model(int t, logic [63:0] z, logic [31:0] b,
                                output logic [31:0] a, output logic err);
    logic [63:0] bz, d;
    bz = {32'b0, b};
    case (t)
      0: begin
        a   = {31'b0, z[63]};
        err = (z[62:0] != 0) || (z[63] && !b[0]);
      end
      1: begin
        d = z + bz; a = d[31:0]; err = (d > 64'hFFFF_FFFF);
      end
      2: begin
        d = z - bz; a = d[32:1];
        err = (z < bz) || d[0] || (d >= 64'h2_0000_0000);
      end
      default: begin
        d = bz - z; a = d[31:0]; err = (d > 64'hFFFF_FFFF);
      end
    endcase
  endfunction

  task automatic run_job(logic [63:0] z, logic [31:0] b, int hold,
                         int lit_t, logic [31:0] lit_a, logic lit_err);
    logic [31:0] ea [NI];
    logic        ee [NI];
    int          done_at [NI];
    int          last, lat;
    for (int i = 0; i < NI; i++) begin
      model(TYP[i], z, b, ea[i], ee[i]);
      done_at[i] = (hold > 0) ? 66 + hold : 64 / WID[i] + 2;
    end
    last      = (hold > 0) ? 66 + hold : 66;
    z_in      = z;
    b_in      = b;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    z_in     = ~z;
    b_in     = ~b;
    for (int c = 1; c <= last; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
        lat = 64 / WID[i] + 1;
        if (c < lat) begin
          chk("calc_flags", i, {out_valid_v[i], in_ready_v[i], busy_v[i]}, 3'b001);
        end else if (c < done_at[i]) begin
          chk("done_flags", i, {out_valid_v[i], in_ready_v[i], busy_v[i]}, 3'b101);
          chk("a_out", i, a_v[i], ea[i]);
          chk("err_out", i, err_v[i], ee[i]);
          if (TYP[i] == lit_t) begin
            chk("a_lit", i, a_v[i], lit_a);
            chk("err_lit", i, err_v[i], lit_err);
          end
        end else if (c == done_at[i]) begin
          chk("idle_flags", i, {out_valid_v[i], in_ready_v[i], busy_v[i]}, 3'b010);
        end
      end
      if (hold > 0 && c == 65 + hold) out_ready = 1'b1;
    end
  endtask

  task automatic chk_reset_values(string name);
    for (int i = 0; i < NI; i++) begin
      chk({name, "_flags"}, i, {out_valid_v[i], in_ready_v[i], busy_v[i]}, 3'b010);
      chk({name, "_a"}, i, a_v[i], 32'h0);
      chk({name, "_err"}, i, err_v[i], 1'b0);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_job(64'h5, 32'd3, 0, 1, 32'd8, 1'b0);
    run_job(64'hFFFF_FFFF_FFFF_FFFF, 32'd1, 0, 1, 32'd0, 1'b0);
    run_job(64'h1_0000_0000, 32'd0, 0, 1, 32'd0, 1'b1);
    run_job(64'd43, 32'd3, 0, 2, 32'd20, 1'b0);
    run_job(64'd44, 32'd3, 0, 2, 32'd20, 1'b1);
    run_job(64'd2, 32'd3, 0, 2, 32'hFFFF_FFFF, 1'b1);
    run_job(64'hFFFF_FFFF_FFFF_FFFE, 32'd5, 0, 3, 32'd7, 1'b0);
    run_job(64'h8000_0000_0000_0000, 32'd1, 0, 0, 32'd1, 1'b0);
    run_job(64'h8000_0000_0000_0000, 32'd0, 0, 0, 32'd1, 1'b1);
    run_job(64'h1, 32'd1, 0, 0, 32'd0, 1'b1);
    run_job(64'h1234, 32'h10, 5, 1, 32'h1244, 1'b0);
    run_job(64'h0000_0001_2345_6789, 32'h89AB_CDEF, 0, 1, 32'hACF1_3578, 1'b1);
    run_job(64'h0000_0000_FFFF_FFFF, 32'hFFFF_FFFF, 0, 2, 32'h0, 1'b0);
    run_job(64'hFFFF_FFFF_0000_0001, 32'h0000_0002, 0, 3, 32'h0000_0001, 1'b1);

    z_in      = 64'h0000_0000_DEAD_BEEF;
    b_in      = 32'h1234_5678;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_values("async_reset");
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_values("post_reset");
    run_job(64'd10, 32'd10, 0, 1, 32'd20, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
